// File: rtl/jesd204_pkg.sv
// Shared JESD204B definitions: control characters, ILA layout constants,
// ILA sequencer state encoding, link-mux selects and the ILA octet payload.
package jesd204_pkg;

  localparam int unsigned MFO_W      = 13;  // octet-in-multiframe counter width
  localparam int unsigned MFL_W      = 14;  // multiframe length width (up to 8192)
  localparam int unsigned MFI_W      = 8;   // multiframe index width
  localparam int unsigned CFG_OCTETS = 14;  // link-config octets after /Q/
  localparam int unsigned CFG_IDX_W  = 4;
  // /R/ + /Q/ + config block + /A/ must fit in one multiframe
  localparam int unsigned MIN_MF_LEN = CFG_OCTETS + 3;

  localparam logic [7:0] K28_0 = 8'h1C;  // /R/
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/

  typedef enum logic [1:0] {
    ILA_IDLE = 2'd0,
    ILA_RUN  = 2'd1,
    ILA_DONE = 2'd2
  } ila_state_t;

  typedef enum logic [1:0] {
    LMUX_DATA = 2'd0,
    LMUX_CGS  = 2'd1,
    LMUX_ILA  = 2'd2,
    LMUX_TEST = 2'd3
  } lmux_sel_t;

  typedef struct packed {
    logic [7:0]       octet;
    logic             is_k;
    logic             mf_start;
    logic [MFI_W-1:0] mf_index;
  } ila_octet_t;

endpackage

// File: rtl/ila_pos_counter.sv
// Nested octet-position / multiframe counter for the ILA sequence.
//   clk, rst      : clock, async active-high reset
//   clr           : synchronous clear of both counters (priority over en)
//   en            : advance one octet
//   last_pos      : position of the last octet in a multiframe (mf_len-1)
//   last_mf       : index of the last multiframe (N-1)
//   pos, mf       : current octet position and multiframe index
//   seq_last_c    : current position is the final octet of the sequence
module ila_pos_counter
  import jesd204_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [MFO_W-1:0] last_pos,
  input  logic [MFI_W-1:0] last_mf,
  output logic [MFO_W-1:0] pos,
  output logic [MFI_W-1:0] mf,
  output logic             seq_last_c
);

  logic pos_wrap_c;
  logic mf_last_c;

  assign pos_wrap_c = (pos == last_pos);
  assign mf_last_c  = (mf == last_mf);
  assign seq_last_c = pos_wrap_c & mf_last_c;

  // Position wraps at the end of a multiframe; the index saturates at N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
      mf  <= '0;
    end else if (clr) begin
      pos <= '0;
      mf  <= '0;
    end else if (en) begin
      if (pos_wrap_c) begin
        pos <= '0;
        if (!mf_last_c) mf <= mf + MFI_W'(1);
      end else begin
        pos <= pos + MFO_W'(1);
      end
    end
  end

endmodule

// File: rtl/ila_sequencer.sv
// JESD204B initial lane alignment octet generator for one lane.
//   clk, rst                : clock, async active-high reset
//   i_start / i_abort       : begin sequence (IDLE only) / terminate immediately
//   i_octet_en              : one octet slot this cycle
//   i_F, i_K                : octets/frame - 1, frames/multiframe - 1
//   i_ila_multiframe_length : ILA multiframes - 1
//   i_cfg_octet, o_cfg_idx  : same-cycle link-config octet lookup
//   o_valid, o_octet, o_is_k, o_mf_start, o_mf_index : registered octet stream
//   o_busy, o_done          : sequence in progress / one-cycle completion pulse
//   o_cfg_err               : current configuration cannot carry an ILA
module ila_sequencer
  import jesd204_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_octet_en,
  input  logic [7:0]           i_F,
  input  logic [4:0]           i_K,
  input  logic [7:0]           i_ila_multiframe_length,
  input  logic [7:0]           i_cfg_octet,
  output logic [CFG_IDX_W-1:0] o_cfg_idx,
  output logic                 o_valid,
  output logic [7:0]           o_octet,
  output logic                 o_is_k,
  output logic                 o_mf_start,
  output logic [MFI_W-1:0]     o_mf_index,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cfg_err
);

  ila_state_t       state;
  logic [MFL_W-1:0] mf_len_c;
  logic [MFL_W-1:0] mf_len_q;
  logic [MFI_W-1:0] n_last_q;
  logic [MFO_W-1:0] last_pos_c;
  logic [MFO_W-1:0] pos;
  logic [MFI_W-1:0] mf;
  logic             seq_last_c;
  logic             cnt_en_c;
  logic             cnt_clr_c;
  logic             in_cfg_c;
  ila_octet_t       oct_c;
  ila_octet_t       oct_q;

  assign mf_len_c  = (MFL_W'(i_F) + MFL_W'(1)) * (MFL_W'(i_K) + MFL_W'(1));
  assign o_cfg_err = (mf_len_c < MFL_W'(MIN_MF_LEN)) | (i_ila_multiframe_length == 8'd0);

  assign last_pos_c = MFO_W'(mf_len_q - MFL_W'(1));
  assign cnt_en_c   = (state == ILA_RUN) & i_octet_en & ~i_abort;
  // Counters are held at zero whenever no sequence is running
  assign cnt_clr_c  = i_abort | (state != ILA_RUN);

  ila_pos_counter u_pos_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr_c),
    .en         (cnt_en_c),
    .last_pos   (last_pos_c),
    .last_mf    (n_last_q),
    .pos        (pos),
    .mf         (mf),
    .seq_last_c (seq_last_c)
  );

  // Config block occupies positions 2..CFG_OCTETS+1 of multiframe 1
  assign in_cfg_c  = (mf == MFI_W'(1)) && (pos >= MFO_W'(2)) &&
                     (pos < MFO_W'(CFG_OCTETS + 2));
  assign o_cfg_idx = in_cfg_c ? CFG_IDX_W'(pos - MFO_W'(2)) : '0;

  // Octet decode for the current (mf, pos)
  always_comb begin
    oct_c          = '0;
    oct_c.octet    = pos[7:0];
    oct_c.is_k     = 1'b0;
    oct_c.mf_start = (pos == '0);
    oct_c.mf_index = mf;
    if (pos == '0) begin
      oct_c.octet = K28_0;
      oct_c.is_k  = 1'b1;
    end else if (pos == last_pos_c) begin
      oct_c.octet = K28_3;
      oct_c.is_k  = 1'b1;
    end else if ((mf == MFI_W'(1)) && (pos == MFO_W'(1))) begin
      oct_c.octet = K28_4;
      oct_c.is_k  = 1'b1;
    end else if (in_cfg_c) begin
      oct_c.octet = i_cfg_octet;
    end
  end

  assign o_octet    = oct_q.octet;
  assign o_is_k     = oct_q.is_k;
  assign o_mf_start = oct_q.mf_start;
  assign o_mf_index = oct_q.mf_index;

  // Sequencer FSM with registered outputs; abort overrides every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ILA_IDLE;
      mf_len_q <= '0;
      n_last_q <= '0;
      oct_q    <= '0;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      if (i_abort) begin
        state  <= ILA_IDLE;
        oct_q  <= '0;
        o_busy <= 1'b0;
      end else begin
        case (state)
          ILA_IDLE: begin
            o_busy <= 1'b0;
            if (i_start && !o_cfg_err) begin
              mf_len_q <= mf_len_c;
              n_last_q <= i_ila_multiframe_length;
              state    <= ILA_RUN;
              o_busy   <= 1'b1;
            end
          end
          ILA_RUN: begin
            o_busy <= 1'b1;
            if (i_octet_en) begin
              o_valid <= 1'b1;
              oct_q   <= oct_c;
              if (seq_last_c) state <= ILA_DONE;
            end
          end
          ILA_DONE: begin
            o_busy <= 1'b1;
            o_done <= 1'b1;
            state  <= ILA_IDLE;
          end
          default: begin
            o_busy <= 1'b0;
            state  <= ILA_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ila_sequencer.sv
// Scoreboard bench for ila_sequencer: stimulus pushes expected octets,
// a monitor pops and compares on every o_valid.
module tb_ila_sequencer;

  typedef struct packed {
    logic [7:0] octet;
    logic       k;
    logic       mfs;
    logic [7:0] mfi;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, octet_en;
  logic [7:0] cfg_f;
  logic [4:0] cfg_k;
  logic [7:0] cfg_l;
  logic [7:0] cfg_octet;
  logic [3:0] cfg_idx;
  logic       valid, is_k, mf_start, busy, done, cfg_err;
  logic [7:0] octet, mf_index;

  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  // Link-config table seen by the sequencer: entry i = 0x50 + 7*i
  assign cfg_octet = 8'h50 + {1'b0, cfg_idx, 3'b000} - {4'b0000, cfg_idx};

  ila_sequencer dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_start                 (start),
    .i_abort                 (abort),
    .i_octet_en              (octet_en),
    .i_F                     (cfg_f),
    .i_K                     (cfg_k),
    .i_ila_multiframe_length (cfg_l),
    .i_cfg_octet             (cfg_octet),
    .o_cfg_idx               (cfg_idx),
    .o_valid                 (valid),
    .o_octet                 (octet),
    .o_is_k                  (is_k),
    .o_mf_start              (mf_start),
    .o_mf_index              (mf_index),
    .o_busy                  (busy),
    .o_done                  (done),
    .o_cfg_err               (cfg_err)
  );

  function automatic exp_t model(int mf, int pos, int mflen);
    exp_t e;
    e.octet = 8'(pos);
    e.k     = 1'b0;
    if (pos == 0) begin
      e.octet = 8'h1C; e.k = 1'b1;
    end else if (pos == mflen - 1) begin
      e.octet = 8'h7C; e.k = 1'b1;
    end else if (mf == 1 && pos == 1) begin
      e.octet = 8'h9C; e.k = 1'b1;
    end else if (mf == 1 && pos >= 2 && pos <= 15) begin
      e.octet = 8'h50 + 8'((pos - 2) * 7);
    end
    e.mfs  = (pos == 0);
    e.mfi  = 8'(mf);
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with o_valid must match the head of the scoreboard
  initial begin
    exp_t act;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (valid || q.size() != 0) begin
        n_vec++;
        if (!valid) begin
          n_err++;
          $display("FAIL valid_missing: got o_valid 0 expected 1 at %0t", $time);
          void'(q.pop_front());
        end else if (q.size() == 0) begin
          n_err++;
          $display("FAIL valid_spurious: got o_valid 1 expected 0 at %0t", $time);
        end else begin
          exp_t e;
          e   = q.pop_front();
          act = {octet, is_k, mf_start, mf_index, busy};
          if (act !== e) begin
            n_err++;
            $display("FAIL octet: got oct=%h k=%b mfs=%b mfi=%0d busy=%b expected oct=%h k=%b mfs=%b mfi=%0d busy=%b at %0t",
                     act.octet, act.k, act.mfs, act.mfi, act.busy,
                     e.octet, e.k, e.mfs, e.mfi, e.busy, $time);
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // One ILA run; optional abort / reset at a global octet index, optional
  // mid-run config change plus spurious start at octet 20.
  task automatic run_seq(input logic [7:0] f, input logic [4:0] k, input logic [7:0] l,
                         input int gap, input int abort_at, input int rst_at, input bit chg);
    int mflen;
    int total;
    int d0;
    mflen = (int'(f) + 1) * (int'(k) + 1);
    total = (int'(l) + 1) * mflen;
    d0    = done_cnt;
    cfg_f = f; cfg_k = k; cfg_l = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < total; i++) begin
      for (int g = 0; g < gap; g++) begin
        octet_en = 1'b0;
        tick();
        check("busy_gap", 32'(busy), 32'd1);
      end
      if (i == abort_at) begin
        abort = 1'b1; octet_en = 1'b1;
        tick();
        abort = 1'b0; octet_en = 1'b0;
        check("valid_after_abort", 32'(valid), 32'd0);
        check("busy_after_abort", 32'(busy), 32'd0);
        repeat (3) tick();
        check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
        return;
      end
      if (i == rst_at) begin
        octet_en = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("async_rst_outputs",
                 32'({valid, busy, done, is_k, mf_start, octet, mf_index, cfg_idx}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("busy_after_rst", 32'(busy), 32'd0);
        check("valid_after_rst", 32'(valid), 32'd0);
        return;
      end
      if (chg && i == 20) begin
        cfg_k = 5'd3;
        start = 1'b1;
      end
      octet_en = 1'b1;
      tick();
      start = 1'b0;
      q.push_back(model(i / mflen, i % mflen, mflen));
    end
    octet_en = 1'b0;
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    tick();
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic cfg_probe(input logic [7:0] f, input logic [4:0] k, input logic [7:0] l,
                           input logic exp_err);
    cfg_f = f; cfg_k = k; cfg_l = l;
    #1 check("cfg_err", 32'(cfg_err), 32'(exp_err));
    if (exp_err) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("busy_cfg_err_start", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; octet_en = 1'b0;
    cfg_f = 8'd0; cfg_k = 5'd16; cfg_l = 8'd3;
    #3 check("reset_outputs",
             32'({valid, busy, done, is_k, mf_start, octet, mf_index, cfg_idx}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: 17-octet multiframes, continuous enable
    run_seq(8'd0, 5'd16, 8'd3, 0, -1, -1, 1'b0);
    // 2: 32-octet multiframes, enable one cycle in three
    run_seq(8'd1, 5'd15, 8'd3, 2, -1, -1, 1'b0);
    // 3: abort at mf 2 pos 5, then clean restart
    run_seq(8'd0, 5'd16, 8'd3, 0, 39, -1, 1'b0);
    run_seq(8'd0, 5'd16, 8'd3, 0, -1, -1, 1'b0);
    // 4: illegal configurations and boundaries
    cfg_probe(8'd0, 5'd7, 8'd3, 1'b1);
    cfg_probe(8'd0, 5'd16, 8'd0, 1'b1);
    cfg_probe(8'd0, 5'd15, 8'd1, 1'b1);
    cfg_probe(8'd0, 5'd16, 8'd1, 1'b0);
    cfg_probe(8'd255, 5'd31, 8'd255, 1'b0);
    // abort and start together: abort wins
    cfg_f = 8'd0; cfg_k = 5'd16; cfg_l = 8'd3;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("abort_beats_start", 32'(busy), 32'd0);
    // 5: async reset in mf 1, then clean restart
    run_seq(8'd0, 5'd16, 8'd3, 0, -1, 24, 1'b0);
    run_seq(8'd0, 5'd16, 8'd3, 0, -1, -1, 1'b0);
    // 6: config change and start during RUN are ignored
    run_seq(8'd0, 5'd16, 8'd3, 0, -1, -1, 1'b1);

    repeat (3) tick();
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
